// File: rtl/lotr_io_pkg.sv
// Shared types and default constants for the lotr I/O debounce block.
package lotr_io_pkg;

   // Which accepted edges latch into the sticky event register.
   typedef enum logic [1:0] {
      RISE = 2'd0,
      FALL = 2'd1,
      BOTH = 2'd2
   } t_edge_sel;

   localparam int unsigned SYNC_STAGES_DEF  = 2;
   localparam int unsigned DEBOUNCE_CNT_DEF = 50000;

   // True when the selection lets rising edges set the sticky bit.
   function automatic logic edge_rise_en(input t_edge_sel sel);
      return (sel == RISE) || (sel == BOTH);
   endfunction

   // True when the selection lets falling edges set the sticky bit.
   function automatic logic edge_fall_en(input t_edge_sel sel);
      return (sel == FALL) || (sel == BOTH);
   endfunction

endpackage

// File: rtl/lotr_debounce_ch.sv
// Single debounce channel: synchronizer chain, stability counter,
// debounced level flop and registered edge pulses.
module lotr_debounce_ch
   import lotr_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic rise_acc,
   output logic fall_acc
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   s;
   logic                   differ;
   logic                   accept;

   assign s = sync_q[SYNC_STAGES-1];

   // Change is accepted on the edge where the counter already holds its
   // last value; rise_acc/fall_acc let the sticky logic set on that same edge.
   always_comb begin
      differ   = (s != stable);
      accept   = differ && (cnt_q == CNT_MAX);
      rise_acc = accept && s;
      fall_acc = accept && !s;
   end

   // Synchronizer chain, oldest sample at the top.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   // Stability counter: clears when stable or on acceptance, otherwise counts.
   always_ff @(posedge clk) begin
      if (rst)                   cnt_q <= '0;
      else if (!differ || accept) cnt_q <= '0;
      else                        cnt_q <= cnt_q + CW'(1);
   end

   // Debounced level and one-cycle edge pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         if (accept) stable <= s;
         rise <= rise_acc;
         fall <= fall_acc;
      end
   end

endmodule

// File: rtl/lotr_io_debounce.sv
// Multi-channel input debouncer with sticky edge events and a summary flag.
module lotr_io_debounce
   import lotr_io_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
   parameter t_edge_sel   EDGE_SEL     = BOTH
) (
   input  logic             QClk,
   input  logic             RstQnnnH,
   input  logic [WIDTH-1:0] RawIn,
   input  logic [WIDTH-1:0] ClrEvt,
   output logic [WIDTH-1:0] StableOut,
   output logic [WIDTH-1:0] RisePulse,
   output logic [WIDTH-1:0] FallPulse,
   output logic [WIDTH-1:0] EvtSticky,
   output logic             AnyEvt
);

   localparam logic RISE_EN = edge_rise_en(EDGE_SEL);
   localparam logic FALL_EN = edge_fall_en(EDGE_SEL);

   logic [WIDTH-1:0] rise_acc;
   logic [WIDTH-1:0] fall_acc;
   logic [WIDTH-1:0] evt_set;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      lotr_debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_ch (
         .clk      (QClk),
         .rst      (RstQnnnH),
         .raw      (RawIn[i]),
         .stable   (StableOut[i]),
         .rise     (RisePulse[i]),
         .fall     (FallPulse[i]),
         .rise_acc (rise_acc[i]),
         .fall_acc (fall_acc[i])
      );
   end

   // Edge events enabled by EDGE_SEL, aligned with the pulse-register edge.
   always_comb begin
      evt_set = (rise_acc & {WIDTH{RISE_EN}}) | (fall_acc & {WIDTH{FALL_EN}});
   end

   // Sticky events: write-1-to-clear, a coincident set takes priority.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) EvtSticky <= '0;
      else          EvtSticky <= evt_set | (EvtSticky & ~ClrEvt);
   end

   // Registered summary of all sticky bits.
   always_ff @(posedge QClk) begin
      if (RstQnnnH) AnyEvt <= 1'b0;
      else          AnyEvt <= |EvtSticky;
   end

endmodule

// File: doc/lotr_io_debounce.md
LOTR_IO_DEBOUNCE -- requirements
Module: lotr_io_debounce

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, the number of independent input channels (1..32).
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, the synchronizer flop depth (2..4).
REQ-003 The block SHALL take parameter DEBOUNCE_CNT, default 50000, the consecutive stable cycles required to accept a change (1..2^20).
REQ-004 The block SHALL take parameter EDGE_SEL, default BOTH, which selects the edges (RISE, FALL, BOTH) that set the sticky event bits.
REQ-005 QClk  in  1  SHALL be the single clock; all flops use its rising edge.
REQ-006 RstQnnnH  in  1  SHALL be the synchronous, active-high reset.
REQ-007 RawIn  in  WIDTH  SHALL carry the asynchronous raw inputs (switches, buttons, Arduino_IO).
REQ-008 ClrEvt  in  WIDTH  SHALL be the per-channel write-1-to-clear strobe for EvtSticky.
REQ-009 StableOut  out  WIDTH  SHALL present the debounced level per channel.
REQ-010 RisePulse  out  WIDTH  SHALL give a one-cycle pulse per channel on an accepted 0->1 change.
REQ-011 FallPulse  out  WIDTH  SHALL give a one-cycle pulse per channel on an accepted 1->0 change.
REQ-012 EvtSticky  out  WIDTH  SHALL hold the latched edge events per channel until cleared.
REQ-013 AnyEvt  out  1  SHALL be the registered OR-reduction of EvtSticky.

Function
REQ-014 Each channel SHALL pass RawIn through a SYNC_STAGES flop chain; the last stage is the synced value s.
REQ-015 Each channel SHALL own a counter of width $clog2(DEBOUNCE_CNT+1) that saturates at DEBOUNCE_CNT-1 and never wraps.
REQ-016 When s equals StableOut, the counter SHALL clear to 0 on the next edge.
REQ-017 When s differs from StableOut and the counter is below DEBOUNCE_CNT-1, the counter SHALL increment.
REQ-018 When s differs and the counter equals DEBOUNCE_CNT-1, StableOut SHALL take s and the counter SHALL clear, both on the same edge.
REQ-019 A glitch shorter than DEBOUNCE_CNT synced cycles SHALL leave StableOut unchanged and SHALL return the counter to 0.
REQ-020 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CNT edges, counting as edge 1 the first edge that samples the new RawIn level held steady.
REQ-021 RisePulse/FallPulse SHALL be registered and high only in the first cycle StableOut shows the new level.
REQ-022 An EvtSticky bit SHALL set on the same edge as its enabled pulse, per EDGE_SEL.
REQ-023 An EvtSticky bit SHALL clear on the edge after ClrEvt is sampled high.
REQ-024 When set and clear coincide, set SHALL win.
REQ-025 AnyEvt SHALL lag EvtSticky by one cycle.
REQ-026 Channels SHALL be fully independent, with no shared counters.

Reset
REQ-027 While RstQnnnH=1 on an edge, sync flops, counters, StableOut, RisePulse, FallPulse, EvtSticky and AnyEvt SHALL all load 0.
REQ-028 Reset asserted mid-count SHALL discard progress without emitting pulses.
REQ-029 An input held 1 through reset release SHALL produce one RisePulse SYNC_STAGES+DEBOUNCE_CNT edges after release.

Structure
REQ-030 Shared package lotr_io_pkg SHALL hold the t_edge_sel enum (RISE, FALL, BOTH) and default constants for SYNC_STAGES and DEBOUNCE_CNT.
REQ-031 Single-channel logic (sync chain, counter, stable flop, pulse flops) SHALL live in sub-module lotr_debounce_ch, generated WIDTH times.
REQ-032 The sticky register, ClrEvt handling and AnyEvt SHALL live in the top of lotr_io_debounce.

Verification
REQ-033 The bench SHALL cover (WIDTH=4, SYNC=2, DEBOUNCE_CNT=4): RawIn[0] 0->1 held -> StableOut[0]=1 and RisePulse[0] high for 1 cycle at edge 6, EvtSticky[0]=1 at edge 6, AnyEvt=1 at edge 7.
REQ-034 The bench SHALL cover: RawIn[1] high for 3 cycles, then low -> StableOut[1] stays 0, no pulse, counter back to 0.
REQ-035 The bench SHALL cover: ClrEvt[0]=1 on the same edge as a new FallPulse[0] -> EvtSticky[0] stays 1, and a ClrEvt[0] on a later cycle clears it.
REQ-036 The bench SHALL cover: EDGE_SEL=RISE with a 1->0 accepted change -> FallPulse high and EvtSticky unchanged.
REQ-037 The bench SHALL cover: RstQnnnH pulsed at counter=2 with RawIn[2]=1 held -> all outputs 0, then RisePulse[2] exactly 6 edges after release.
REQ-038 The bench SHALL cover: DEBOUNCE_CNT=1 with RawIn toggling every cycle -> StableOut follows RawIn delayed by 3 edges, with one pulse per change.
